// File: rtl/skinny_sbox_layer_ctrl.sv
// Byte-serial driver for the two-share masked SKINNY-128 S-box layer: streams the
// state MSB byte first through the S-box and shifts the output shares back in.

module skinny_share_lane (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         issue,
  input  logic         capture,
  input  logic [127:0] din,
  input  logic [7:0]   sb_out,
  output logic [127:0] sh,
  output logic [7:0]   sb_in
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sh <= '0;
    else if (load)    sh <= din;
    else if (capture) sh <= {sh[119:0], sb_out};
  end

  // S-box input is registered so it stays stable for the whole evaluation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sb_in <= '0;
    else if (issue) sb_in <= sh[127:120];
  end
endmodule

module skinny_sbox_layer_ctrl #(
  parameter int SBOX_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_0_i,
  input  logic [127:0] state_1_i,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_0_o,
  output logic [127:0] state_1_o,
  input  logic [75:0]  rnd_i,
  input  logic         rnd_valid_i,
  output logic         rnd_ready_o,
  output logic [7:0]   sb_in_0,
  output logic [7:0]   sb_in_1,
  output logic [75:0]  sb_rnd,
  input  logic [7:0]   sb_out_0,
  input  logic [7:0]   sb_out_1
);
  localparam int NUM_SHARES = 2;
  localparam logic [2:0] LAT_LAST = 3'(SBOX_LAT - 1);

  if (SBOX_LAT < 1 || SBOX_LAT > 7) begin : g_bad_lat
    $error("SBOX_LAT must be in 1..7");
  end

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t state, state_nxt;
  logic [3:0] byte_idx;
  logic [2:0] lat_cnt;
  logic       load, issue, capture, lat_last;

  logic [NUM_SHARES-1:0][127:0] sh, din;
  logic [NUM_SHARES-1:0][7:0]   sb_in, sb_out;

  assign lat_last = (lat_cnt == LAT_LAST);
  assign load     = (state == IDLE)  && start;
  assign issue    = (state == FETCH) && rnd_valid_i;
  assign capture  = (state == EVAL)  && lat_last;

  assign din    = {state_1_i, state_0_i};
  assign sb_out = {sb_out_1, sb_out_0};

  // one lane per share; shares never meet inside this block
  for (genvar g = 0; g < NUM_SHARES; g++) begin : g_lane
    skinny_share_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .issue   (issue),
      .capture (capture),
      .din     (din[g]),
      .sb_out  (sb_out[g]),
      .sh      (sh[g]),
      .sb_in   (sb_in[g])
    );
  end

  assign state_0_o = sh[0];
  assign state_1_o = sh[1];
  assign sb_in_0   = sb_in[0];
  assign sb_in_1   = sb_in[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (rnd_valid_i) state_nxt = EVAL;
      EVAL:    if (lat_last) state_nxt = (byte_idx == 4'd15) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    rnd_ready_o = (state == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       byte_idx <= '0;
    else if (load)    byte_idx <= '0;
    else if (capture) byte_idx <= byte_idx + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              lat_cnt <= '0;
    else if (issue)          lat_cnt <= '0;
    else if (state == EVAL)  lat_cnt <= lat_cnt + 3'd1;
  end

  // one randomness word per S-box evaluation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sb_rnd <= '0;
    else if (issue) sb_rnd <= rnd_i;
  end
endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// Directed bench for skinny_sbox_layer_ctrl with a behavioural masked S-box
// (latency 2 and latency 3 instances) built from the SKINNY 8-bit S-box circuit.

module tb_skinny_sbox_layer_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [127:0] state_0_i = '0, state_1_i = '0;
  logic start_a = 1'b0, start_b = 1'b0, rnd_valid = 1'b1;
  logic [75:0] rnd_a, rnd_b;

  logic busy_a, done_a, rdy_a, busy_b, done_b, rdy_b;
  logic [127:0] o0_a, o1_a, o0_b, o1_b;
  logic [7:0] in0_a, in1_a, out0_a, out1_a, in0_b, in1_b, out0_b, out1_b;
  logic [75:0] sbr_a, sbr_b;
  logic [15:0] pa, pb0, pb1;

  int checks = 0, failures = 0, ka = 0, kb = 0;
  int n, m, k0;
  logic [127:0] s0, s1, e0, e1, f0, f1;

  always #5 clk = ~clk;

  skinny_sbox_layer_ctrl #(.SBOX_LAT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .state_0_i(state_0_i), .state_1_i(state_1_i),
    .busy(busy_a), .done(done_a), .state_0_o(o0_a), .state_1_o(o1_a),
    .rnd_i(rnd_a), .rnd_valid_i(rnd_valid), .rnd_ready_o(rdy_a),
    .sb_in_0(in0_a), .sb_in_1(in1_a), .sb_rnd(sbr_a), .sb_out_0(out0_a), .sb_out_1(out1_a));

  skinny_sbox_layer_ctrl #(.SBOX_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .state_0_i(state_0_i), .state_1_i(state_1_i),
    .busy(busy_b), .done(done_b), .state_0_o(o0_b), .state_1_o(o1_b),
    .rnd_i(rnd_b), .rnd_valid_i(rnd_valid), .rnd_ready_o(rdy_b),
    .sb_in_0(in0_b), .sb_in_1(in1_b), .sb_rnd(sbr_b), .sb_out_0(out0_b), .sb_out_1(out1_b));

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = x;
    for (int r = 0; r < 4; r++) begin
      y[4] = y[4] ^ ~(y[7] | y[6]);
      y[0] = y[0] ^ ~(y[3] | y[2]);
      if (r < 3) y = {y[2], y[1], y[7], y[6], y[4], y[0], y[3], y[5]};
      else       y = {y[7:3], y[1], y[2], y[0]};
    end
    return y;
  endfunction

  function automatic logic [7:0] fold(input logic [75:0] r);
    logic [79:0] t;
    logic [7:0] y;
    t = {4'h0, r};
    y = '0;
    for (int i = 0; i < 10; i++) y = y ^ t[8*i +: 8];
    return y;
  endfunction

  function automatic logic [75:0] rnd_word(input int k);
    logic [31:0] kk;
    kk = k + 1;
    return {kk[3:0], 72'(kk) * 72'h9E3779B97F4A7C15A5};
  endfunction

  // output share 1 is derived from the randomness, share 0 carries S(x) ^ share 1
  function automatic logic [15:0] sbox_model(input logic [7:0] i0, input logic [7:0] i1,
                                              input logic [75:0] r);
    logic [7:0] mk;
    mk = fold(r);
    return {sbox(i0 ^ i1) ^ mk, mk};
  endfunction

  function automatic void expect_res(input logic [127:0] a0, input logic [127:0] a1, input int kbase,
                                     output logic [127:0] x0, output logic [127:0] x1);
    logic [7:0] mk;
    x0 = '0;
    x1 = '0;
    for (int b = 0; b < 16; b++) begin
      mk = fold(rnd_word(kbase + b));
      x1[127-8*b -: 8] = mk;
      x0[127-8*b -: 8] = sbox(a0[127-8*b -: 8] ^ a1[127-8*b -: 8]) ^ mk;
    end
  endfunction

  // S-box latency model: output reflects inputs only after SBOX_LAT edges
  always @(posedge clk) pa <= sbox_model(in0_a, in1_a, sbr_a);
  assign {out0_a, out1_a} = pa;
  always @(posedge clk) begin
    pb0 <= sbox_model(in0_b, in1_b, sbr_b);
    pb1 <= pb0;
  end
  assign {out0_b, out1_b} = pb1;

  always @(posedge clk) begin
    if (rnd_valid && rdy_a) ka <= ka + 1;
    if (rnd_valid && rdy_b) kb <= kb + 1;
  end
  assign rnd_a = rnd_word(ka);
  assign rnd_b = rnd_word(kb);

  task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic run_op(input bit sel, input logic [127:0] a0, input logic [127:0] a1,
                        input bit stall, input bit pulses, input int exp_n, input string tag);
    logic [127:0] x0, x1;
    logic [351:0] snap;
    logic [75:0] prev, cur;
    int kbase, cnt, per, chg, bad;
    per = sel ? 4 : 3;
    @(negedge clk);
    state_0_i = a0;
    state_1_i = a1;
    kbase = sel ? kb : ka;
    prev = sel ? sbr_b : sbr_a;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    state_0_i = ~a0;
    state_1_i = a1 ^ 128'h5A;
    chk({tag, "_fetch_flags"}, sel ? {busy_b, rdy_b, done_b} : {busy_a, rdy_a, done_a}, 3'b110);
    cnt = 0; chg = 0; bad = 0; snap = '0;
    while (cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      cur = sel ? sbr_b : sbr_a;
      if (cur !== prev) begin
        chg++;
        if ((cnt - 1) % per != 0) bad++;
      end
      prev = cur;
      if (stall && cnt == 9) begin
        rnd_valid = 1'b0;
        snap = sel ? {in0_b, in1_b, sbr_b, o0_b, o1_b} : {in0_a, in1_a, sbr_a, o0_a, o1_a};
      end
      if (stall && cnt == 14) begin
        chk({tag, "_stall_hold"},
            sel ? {in0_b, in1_b, sbr_b, o0_b, o1_b} : {in0_a, in1_a, sbr_a, o0_a, o1_a}, snap);
        rnd_valid = 1'b1;
      end
      if (pulses && (cnt == 9 || cnt == 29))  set_start(sel, 1'b1);
      if (pulses && (cnt == 10 || cnt == 30)) set_start(sel, 1'b0);
      if (sel ? done_b : done_a) break;
    end
    chk({tag, "_latency"}, 352'(cnt), 352'(exp_n));
    if (!stall) chk({tag, "_word_hold"}, {32'(chg), 32'(bad)}, {32'd16, 32'd0});
    expect_res(a0, a1, kbase, x0, x1);
    chk({tag, "_share0"}, sel ? o0_b : o0_a, x0);
    chk({tag, "_share1"}, sel ? o1_b : o1_a, x1);
    @(posedge clk); #1;
    chk({tag, "_after_done"}, sel ? {done_b, busy_b, o0_b, o1_b} : {done_a, busy_a, o0_a, o1_a},
        {2'b00, x0, x1});
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_a", {busy_a, done_a, rdy_a, o0_a, o1_a, in0_a, in1_a, sbr_a}, '0);
    chk("rst_async_b", {busy_b, done_b, rdy_b, o0_b, o1_b, in0_b, in1_b, sbr_b}, '0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle_a", {busy_a, done_a, rdy_a, o0_a, o1_a, in0_a, in1_a, sbr_a}, '0);
    chk("rst_idle_b", {busy_b, done_b, rdy_b, o0_b, o1_b, in0_b, in1_b, sbr_b}, '0);

    // plaintext 0x00..00 -> 0x65 per byte, plaintext 0xFF..FF -> 0xFF per byte
    s1 = {$urandom, $urandom, $urandom, $urandom};
    run_op(1'b0, s1, s1, 1'b0, 1'b0, 48, "zero");
    chk("zero_unmasked", o0_a ^ o1_a, {16{8'h65}});
    s1 = {$urandom, $urandom, $urandom, $urandom};
    run_op(1'b0, ~s1, s1, 1'b0, 1'b0, 48, "ones");
    chk("ones_unmasked", o0_a ^ o1_a, {16{8'hFF}});

    for (int i = 0; i < 256; i++) begin
      s0 = {$urandom, $urandom, $urandom, $urandom};
      s1 = {$urandom, $urandom, $urandom, $urandom};
      run_op(1'b0, s0, s1, 1'b0, 1'b0, 48, "rand");
    end

    s0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    s1 = {$urandom, $urandom, $urandom, $urandom};
    run_op(1'b0, s0, s1, 1'b1, 1'b0, 53, "stall");
    run_op(1'b0, s1, s0, 1'b0, 1'b1, 48, "ignored_start");

    // start held: the DONE cycle plus one IDLE cycle separate the two done pulses
    s0 = {$urandom, $urandom, $urandom, $urandom};
    s1 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    state_0_i = s0;
    state_1_i = s1;
    k0 = ka;
    start_a = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (done_a) break;
    end
    chk("b2b_first_latency", 352'(n), 352'd48);
    expect_res(s0, s1, k0, e0, e1);
    chk("b2b_first_result", {o0_a, o1_a}, {e0, e1});
    m = 0;
    while (m < 300) begin
      @(posedge clk); #1;
      m++;
      if (m == 2) start_a = 1'b0;
      if (done_a) break;
    end
    chk("b2b_spacing", 352'(m), 352'd50);
    expect_res(s0, s1, k0 + 16, e0, e1);
    chk("b2b_second_result", {o0_a, o1_a}, {e0, e1});
    start_a = 1'b0;

    // reset during EVAL of byte 7
    @(negedge clk);
    state_0_i = s1;
    state_1_i = s0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (22) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_op", {busy_a, done_a, rdy_a, o0_a, o1_a, in0_a, in1_a, sbr_a}, '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_stays_idle", {busy_a, done_a, rdy_a, o0_a, o1_a, in0_a, in1_a, sbr_a}, '0);
    run_op(1'b0, s0, s1, 1'b0, 1'b0, 48, "after_rst");

    run_op(1'b1, s1, s1, 1'b0, 1'b0, 64, "lat3_zero");
    chk("lat3_zero_unmasked", o0_b ^ o1_b, {16{8'h65}});
    for (int i = 0; i < 4; i++) begin
      s0 = {$urandom, $urandom, $urandom, $urandom};
      s1 = {$urandom, $urandom, $urandom, $urandom};
      run_op(1'b1, s0, s1, 1'b0, 1'b0, 64, "lat3_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
